// File: rtl/ifmp1_feeder.sv
// ifmp1_feeder: master-side producer for the ifmp1 interface.
// Words arriving on a valid/ready stream are buffered in a small FIFO. The
// head word is presented on sig1 and advances only when the slave pulses
// sig2. The block also counts acknowledges that arrive with nothing
// presented (underruns) and flags a presented word that waits too long
// (timeout).
module ifmp1_feeder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] IDLE_WORD = 32'h0000_0000,
    parameter int          TIMEOUT   = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [31:0]                  sig1,
    input  logic                         sig2,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  underrun_cnt,
    output logic                         timeout,
    input  logic                         clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    // Saturation point of the wait counter and the value one step before it;
    // the timeout event fires only on the step that reaches saturation.
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
    localparam logic [WW-1:0] WAIT_PRE = WW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic {
        S_EMPTY   = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    // Storage. The head entry is copied into sig1_q, so the array itself is
    // only ever read to compute the next registered output.
    logic [31:0]   mem_q [DEPTH];

    state_t        state_q,  state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [31:0]   sig1_q,   sig1_d;
    logic [WW-1:0] wait_q,   wait_d;
    logic [15:0]   under_q,  under_d;
    logic          tmo_q,    tmo_d;

    logic          push;
    logic          pop;
    logic          underrun_ev;
    logic          tmo_ev;
    logic [LW-1:0] level_after_pop;

    // No bypass: readiness depends only on the registered occupancy, so a
    // full FIFO refuses a push even while it is popping.
    assign in_ready = (level_q < LEVEL_FULL);

    // Handshake decode: an acknowledge pops only when a word is presented;
    // otherwise it is an underrun and has no effect on the FIFO.
    always_comb begin
        push        = in_valid && in_ready;
        pop         = sig2 && (state_q == S_PRESENT);
        underrun_ev = sig2 && (state_q == S_EMPTY);
    end

    // FIFO pointers, occupancy, next presented word and next state.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_after_pop = level_q - LW'(pop);
        level_d         = level_after_pop + LW'(push);
        sig1_d          = IDLE_WORD;
        state_d         = S_EMPTY;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (level_d != '0) begin
            state_d = S_PRESENT;
            // When nothing older survives the pop, the new head is the word
            // being written this very cycle and is not yet in the array.
            if (level_after_pop == '0) begin
                sig1_d = in_data;
            end else begin
                sig1_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Wait counter and the sticky status flags; clr overrides any event.
    always_comb begin
        wait_d = '0;
        tmo_ev = 1'b0;
        if ((state_q == S_PRESENT) && !pop) begin
            if (wait_q != WAIT_MAX) begin
                wait_d = wait_q + WW'(1);
                tmo_ev = (wait_q == WAIT_PRE);
            end else begin
                wait_d = wait_q;
            end
        end

        if (clr) begin
            tmo_d = 1'b0;
        end else begin
            tmo_d = tmo_q | tmo_ev;
        end

        if (clr) begin
            under_d = '0;
        end else if (underrun_ev && (under_q != 16'hFFFF)) begin
            under_d = under_q + 16'd1;
        end else begin
            under_d = under_q;
        end
    end

    // Buffer write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control state and registered outputs; reset discards buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sig1_q   <= IDLE_WORD;
            wait_q   <= '0;
            under_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sig1_q   <= sig1_d;
            wait_q   <= wait_d;
            under_q  <= under_d;
            tmo_q    <= tmo_d;
        end
    end

    assign sig1         = sig1_q;
    assign level        = level_q;
    assign underrun_cnt = under_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_ifmp1_feeder.sv
// Testbench for ifmp1_feeder: scoreboard queue of accepted words, popped and
// compared against sig1 whenever the bench acknowledges a presented word.
module tb_ifmp1_feeder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] IDLE  = 32'h0000_0000;
    localparam int          TMO   = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sig1;
    logic        sig2;
    logic [2:0]  level;
    logic [15:0] underrun_cnt;
    logic        timeout;
    logic        clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q [$];

    ifmp1_feeder #(
        .DEPTH     (DEPTH),
        .IDLE_WORD (IDLE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sig1         (sig1),
        .sig2         (sig2),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .timeout      (timeout),
        .clr          (clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus and update the scoreboard from the
    // bench's own view of occupancy (no bypass when full).
    task automatic cycle(input logic v, input logic [31:0] d, input logic ack,
                         input logic c, output logic acc);
        logic        popped;
        logic [31:0] gone;
        in_valid = v;
        in_data  = d;
        sig2     = ack;
        clr      = c;
        acc      = v && (sb_q.size() < DEPTH);
        popped   = ack && (sb_q.size() > 0);
        tick();
        if (popped) begin
            gone = sb_q.pop_front();
            $display("pop   %08h  (queue now %0d)", gone, sb_q.size());
        end else if (ack) begin
            $display("ack with nothing presented");
        end
        if (acc) begin
            sb_q.push_back(d);
            $display("push  %08h  (queue now %0d)", d, sb_q.size());
        end
        in_valid = 1'b0;
        sig2     = 1'b0;
        clr      = 1'b0;
    endtask

    function automatic logic [31:0] sb_head();
        return (sb_q.size() > 0) ? sb_q[0] : IDLE;
    endfunction

    task automatic test_reset();
        n_checks++; if (sig1 !== IDLE) begin n_fail++; $display("FAIL reset_sig1: got %08h want %08h", sig1, IDLE); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_single();
        logic        acc;
        logic [31:0] exp;
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, acc);
        n_checks++; if (sig1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_sig1: got %08h want DEADBEEF", sig1); end
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
        exp = sb_head();
        n_checks++; if (sig1 !== exp) begin n_fail++; $display("FAIL single_pop_word: got %08h want %08h", sig1, exp); end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++; if (sig1 !== IDLE) begin n_fail++; $display("FAIL single_idle: got %08h want %08h", sig1, IDLE); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_level0: got %0d want 0", level); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] w [5];
        logic        acc;
        logic [31:0] exp;
        int          idx = 0;
        w[0] = 32'hA000_0001; w[1] = 32'hA000_0002; w[2] = 32'hA000_0003;
        w[3] = 32'hA000_0004; w[4] = 32'hA000_0005;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, w[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d want 4", level); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        n_checks++; if (sig1 !== 32'hA000_0001) begin n_fail++; $display("FAIL fill_head: got %08h want A0000001", sig1); end
        // Drain while still offering the held fifth word.
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            exp = sb_head();
            n_checks++; if (sig1 !== exp) begin n_fail++; $display("FAIL wrap_order: got %08h want %08h", sig1, exp); end
            n_checks++; if (in_ready !== (sb_q.size() < DEPTH)) begin n_fail++; $display("FAIL wrap_in_ready: got %b want %b", in_ready, (sb_q.size() < DEPTH)); end
            cycle(idx < 5, (idx < 5) ? w[idx] : 32'h0, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d words left after cycle budget, want 0", sb_q.size()); end
        n_checks++; if (sig1 !== IDLE) begin n_fail++; $display("FAIL wrap_idle: got %08h want %08h", sig1, IDLE); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL wrap_level0: got %0d want 0", level); end
    endtask

    task automatic test_underrun();
        logic acc;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++; if (underrun_cnt !== 16'd3) begin n_fail++; $display("FAIL underrun_cnt3: got %0d want 3", underrun_cnt); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL underrun_level: got %0d want 0", level); end
        n_checks++; if (sig1 !== IDLE) begin n_fail++; $display("FAIL underrun_sig1: got %08h want %08h", sig1, IDLE); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n_checks++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL underrun_clr: got %0d want 0", underrun_cnt); end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL underrun_cnt1: got %0d want 1", underrun_cnt); end
        cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
        n_checks++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL underrun_clr_wins: got %0d want 0", underrun_cnt); end
    endtask

    task automatic test_timeout();
        logic        acc;
        logic [31:0] exp;
        cycle(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, acc);
        for (int i = 0; i < TMO - 1; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0 at cycle %0d", timeout, TMO - 1); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b want 1 at cycle %0d", timeout, TMO); end
        n_checks++; if (sig1 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL timeout_sig1_held: got %08h want 5555AAAA", sig1); end
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL timeout_level: got %0d want 1", level); end
        exp = sb_head();
        n_checks++; if (sig1 !== exp) begin n_fail++; $display("FAIL timeout_pop_word: got %08h want %08h", sig1, exp); end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", timeout); end
        n_checks++; if (sig1 !== IDLE) begin n_fail++; $display("FAIL timeout_idle: got %08h want %08h", sig1, IDLE); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b want 0", timeout); end
    endtask

    task automatic test_back_to_back();
        logic        acc;
        logic [31:0] exp;
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0, acc);
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL b2b_level_pre: got %0d want 1", level); end
        exp = sb_head();
        n_checks++; if (sig1 !== exp) begin n_fail++; $display("FAIL b2b_first: got %08h want %08h", sig1, exp); end
        cycle(1'b1, 32'h2222_2222, 1'b1, 1'b0, acc);
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL b2b_level: got %0d want 1", level); end
        n_checks++; if (sig1 !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_second: got %08h want 22222222", sig1); end
        exp = sb_head();
        n_checks++; if (sig1 !== exp) begin n_fail++; $display("FAIL b2b_scoreboard: got %08h want %08h", sig1, exp); end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_level0: got %0d want 0", level); end
    endtask

    task automatic test_async_reset();
        logic acc;
        cycle(1'b1, 32'h0BAD_0001, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0BAD_0002, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0BAD_0003, 1'b0, 1'b0, acc);
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL areset_level_pre: got %0d want 3", level); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (sig1 !== IDLE) begin n_fail++; $display("FAIL areset_sig1: got %08h want %08h", sig1, IDLE); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL areset_level: got %0d want 0", level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
        sb_q.delete();
        #3;
        rst_n = 1'b1;
        tick();
        cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, acc);
        n_checks++; if (sig1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL areset_after: got %08h want CAFEF00D", sig1); end
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL areset_after_level: got %0d want 1", level); end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        sig2     = 1'b0;
        clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single();
        test_fill_wrap();
        test_underrun();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifmp1_feeder.md
Name: ifmp1_feeder

Overview:
- Upstream producer stage for the ifmp1 interface. Drives the master side: the `sig1` word goes out, and the `sig2` acknowledge comes back from the slave.
- Buffers 32-bit words arriving on a valid/ready stream in a small FIFO. Presents them one at a time on `sig1` and advances only on a `sig2` acknowledge.
- Tracks acknowledges that arrive while no word is presented (underruns) and acknowledges that never arrive (timeouts).

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- IDLE_WORD, 32'h0000_0000: value driven on `sig1` while no word is presented.
- TIMEOUT, 256: cycles a presented word may wait for `sig2` before `timeout` sets; minimum 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  32  word to enqueue.
- in_valid  input  1  `in_data` valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- sig1  output  32  ifmp1 master data word, registered.
- sig2  input  1  ifmp1 slave acknowledge; a one-cycle pulse meaning "sig1 consumed".
- level  output  $clog2(DEPTH+1)  FIFO occupancy, including the presented word.
- underrun_cnt  output  16  count of `sig2` pulses seen in EMPTY; saturates at 16'hFFFF.
- timeout  output  1  sticky; a presented word waited TIMEOUT cycles without `sig2`.
- clr  input  1  synchronous clear of `underrun_cnt` and `timeout` only.

Behaviour:
- Reset (asynchronous, active-low):
  - state = EMPTY; FIFO pointers = 0; `level` = 0.
  - `sig1` = IDLE_WORD; `in_ready` = 1; `underrun_cnt` = 0; `timeout` = 0; wait counter = 0.
  - A reset mid-transfer discards all buffered words.
- Enqueue:
  - A push occurs when `in_valid && in_ready`.
  - `in_ready` = (`level` < DEPTH), a combinational function of registered `level`.
  - No bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
- FIFO head: the head entry is the word presented on `sig1`; it remains counted in `level` until acknowledged.
- State EMPTY (`level` = 0):
  - `sig1` = IDLE_WORD.
  - `sig2` high → `underrun_cnt` += 1 (saturating); no other effect.
  - Push → next cycle go to PRESENT with `sig1` = pushed word. Latency is 1 cycle from push to `sig1`.
- State PRESENT (`level` ≥ 1):
  - `sig1` holds the head word, stable until acknowledged.
  - `sig2` high → pop; next cycle `sig1` = next entry, or IDLE_WORD and state EMPTY if the FIFO is now empty.
  - Simultaneous push and pop: `level` unchanged.
  - Push and pop together with `level` = 1 → stay in PRESENT; next cycle `sig1` = the pushed word.
- Wait counter:
  - Cleared on entry to PRESENT and on every pop.
  - Increments each PRESENT cycle without `sig2`, saturating at TIMEOUT.
  - Reaching TIMEOUT sets `timeout`. The word stays presented; no auto-drop.
- `clr`:
  - Clears `underrun_cnt` and `timeout` next cycle.
  - If `clr` coincides with an underrun event or a timeout event, `clr` wins (result 0).
  - Does not affect the FIFO or `sig1`.
- Pointers: wrap modulo DEPTH; `level` is range 0..DEPTH and never overflows or underflows.
- `sig2` while `level` = 0 is the only pop-like event that is ignored; there is never a pop on an empty FIFO.

Test Plan:
- Reset, then push 32'hDEAD_BEEF → next cycle `sig1` = 32'hDEAD_BEEF, `level` = 1; pulse `sig2` → next cycle `sig1` = IDLE_WORD, `level` = 0.
- Push 5 words with DEPTH = 4 and no `sig2` → `in_ready` = 0 after the 4th push, 5th word held upstream; four `sig2` pulses → words appear in order, wrap-around verified.
- Three `sig2` pulses while EMPTY → `underrun_cnt` = 3; assert `clr` → `underrun_cnt` = 0 next cycle.
- Present a word with no `sig2` for TIMEOUT = 256 cycles → `timeout` = 1 at cycle 256, `sig1` unchanged; then `sig2` → pop, `timeout` stays 1 until `clr`.
- `level` = 1 with push and `sig2` in the same cycle → `level` stays 1, `sig1` = new word next cycle, no IDLE_WORD glitch.
- Deassert `rst_n` asynchronously with 3 words buffered → `sig1` = IDLE_WORD, `level` = 0, `in_ready` = 1 immediately, before the next clock edge.
